// File: rtl/sync_fifo_ram.sv
// Synchronous FIFO on an inferred simple dual-port RAM with a registered read,
// optional second output register, occupancy flags and overflow/underflow pulses.
module sync_fifo_ram #(
  parameter int    DATA_WIDTH        = 8,
  parameter int    ADDR_WIDTH        = 9,
  parameter string OUTPUT_REG        = "TRUE",
  parameter int    PROG_FULL_THRESH  = (2 ** ADDR_WIDTH) - 4,
  parameter int    PROG_EMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  prog_full,
  output logic                  prog_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                DEPTH     = 2 ** ADDR_WIDTH;
  localparam bit                TWO_STAGE = (OUTPUT_REG == "TRUE");
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] PF_C    = (ADDR_WIDTH + 1)'(PROG_FULL_THRESH);
  localparam logic [ADDR_WIDTH:0] PE_C    = (ADDR_WIDTH + 1)'(PROG_EMPTY_THRESH);
  localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] data_p1;
  logic [DATA_WIDTH-1:0] data_p2;
  logic                  vld_p1;
  logic                  vld_p2;

  // Flags come straight from the registered count so they move with it.
  assign full       = (count == DEPTH_C);
  assign empty      = (count == '0);
  assign prog_full  = (count >= PF_C);
  assign prog_empty = (count <= PE_C);

  assign wr_acc = wr_en && !full && !rst;
  assign rd_acc = rd_en && !empty && !rst;

  // RAM contents survive reset; only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

  // ---- stage p1: registered RAM read ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= rd_acc;
      if (rd_acc) data_p1 <= mem[rd_ptr[ADDR_WIDTH-1:0]];
    end
  end

  // ---- stage p2: optional output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) data_p2 <= data_p1;
    end
  end

  assign rdata  = TWO_STAGE ? data_p2 : data_p1;
  assign rvalid = TWO_STAGE ? vld_p2  : vld_p1;

endmodule

// File: tb/tb_sync_fifo_ram.sv
// Bench for sync_fifo_ram: a 4-deep FIFO with two output registers and a twin
// with one, driven identically; popped words are checked against a scoreboard.
module tb_sync_fifo_ram;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] wdata = 8'h00;

  logic [7:0] rdata_a, rdata_b;
  logic       rvalid_a, rvalid_b;
  logic [2:0] count_a, count_b;
  logic       full_a, empty_a, pfull_a, pempty_a, ovf_a, udf_a;
  logic       full_b, empty_b, pfull_b, pempty_b, ovf_b, udf_b;

  always #5 clk = ~clk;

  sync_fifo_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .OUTPUT_REG("TRUE"),
                  .PROG_FULL_THRESH(3), .PROG_EMPTY_THRESH(1)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(rdata_a), .rvalid(rvalid_a), .count(count_a), .full(full_a),
    .empty(empty_a), .prog_full(pfull_a), .prog_empty(pempty_a),
    .overflow(ovf_a), .underflow(udf_a));

  sync_fifo_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .OUTPUT_REG("FALSE"),
                  .PROG_FULL_THRESH(3), .PROG_EMPTY_THRESH(1)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(rdata_b), .rvalid(rvalid_b), .count(count_b), .full(full_b),
    .empty(empty_b), .prog_full(pfull_b), .prog_empty(pempty_b),
    .overflow(ovf_b), .underflow(udf_b));

  typedef struct {
    logic [7:0] data;
    int         due;
  } sb_t;

  typedef struct {
    bit         r;
    bit         w;
    logic [7:0] wd;
    bit         rd;
    int         cnt;
    bit         ovf;
    bit         udf;
  } vec_t;

  sb_t        sb_a[$];
  sb_t        sb_b[$];
  logic [7:0] mq[$];
  vec_t       vecs[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_rd_a();
    sb_t e;
    if (rvalid_a === 1'b1) begin
      if (sb_a.size() == 0) chk("rvalid_a_spurious", rvalid_a, 0);
      else begin
        e = sb_a.pop_front();
        chk("rdata_a", rdata_a, e.data);
        chk("latency_a", cyc, e.due);
      end
    end else if (sb_a.size() != 0 && sb_a[0].due <= cyc) begin
      e = sb_a.pop_front();
      chk("rvalid_a_missing", rvalid_a, 1);
    end else begin
      chk("rvalid_a_idle", rvalid_a, 0);
    end
  endtask

  task automatic check_rd_b();
    sb_t e;
    if (rvalid_b === 1'b1) begin
      if (sb_b.size() == 0) chk("rvalid_b_spurious", rvalid_b, 0);
      else begin
        e = sb_b.pop_front();
        chk("rdata_b", rdata_b, e.data);
        chk("latency_b", cyc, e.due);
      end
    end else if (sb_b.size() != 0 && sb_b[0].due <= cyc) begin
      e = sb_b.pop_front();
      chk("rvalid_b_missing", rvalid_b, 1);
    end else begin
      chk("rvalid_b_idle", rvalid_b, 0);
    end
  endtask

  // Drive one cycle, update the reference FIFO, then check after the edge.
  task automatic apply(bit r, bit w, logic [7:0] wd, bit rd, int ecnt, bit eovf, bit eudf);
    bit         wacc;
    bit         racc;
    logic [7:0] rw;
    int         nxt;
    nxt  = cyc + 1;
    racc = !r && rd && (mq.size() != 0);
    wacc = !r && w && (mq.size() != 4);
    if (racc) begin
      rw = mq.pop_front();
      sb_a.push_back('{rw, nxt + 1});
      sb_b.push_back('{rw, nxt});
    end
    if (wacc) mq.push_back(wd);
    if (r) mq.delete();
    rst = r; wr_en = w; wdata = wd; rd_en = rd;
    @(posedge clk);
    #1;
    cyc = nxt;
    if (r) begin
      sb_a.delete();
      sb_b.delete();
      chk("rdata_a_rst", rdata_a, 0);
      chk("rdata_b_rst", rdata_b, 0);
    end
    chk("count_a", count_a, ecnt);
    chk("count_b", count_b, ecnt);
    chk("full", full_a, (ecnt == 4));
    chk("empty", empty_a, (ecnt == 0));
    chk("prog_full", pfull_a, (ecnt >= 3));
    chk("prog_empty", pempty_a, (ecnt <= 1));
    chk("overflow_a", ovf_a, eovf);
    chk("underflow_a", udf_a, eudf);
    chk("overflow_b", ovf_b, eovf);
    chk("underflow_b", udf_b, eudf);
    check_rd_a();
    check_rd_b();
  endtask

  initial begin
    //                  rst  wr   wdata  rd   cnt ovf  udf
    vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h11, 1'b0, 1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h22, 1'b0, 2, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h33, 1'b0, 3, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h44, 1'b0, 4, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h55, 1'b0, 4, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 4, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 3, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 2, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h01, 1'b0, 1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h02, 1'b0, 2, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h03, 1'b1, 2, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h04, 1'b1, 2, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h05, 1'b0, 3, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h06, 1'b0, 4, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h07, 1'b1, 3, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 2, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h08, 1'b1, 1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h09, 1'b0, 1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 8'h0A, 1'b1, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].r, vecs[i].w, vecs[i].wd, vecs[i].rd, vecs[i].cnt, vecs[i].ovf, vecs[i].udf);
    end

    // Streaming with the read one cycle behind the write; pointers wrap twice.
    for (int i = 0; i <= 16; i++) begin
      apply(1'b0, (i < 16), 8'(i), (i >= 1), (i == 16) ? 0 : 1, 1'b0, 1'b0);
    end
    apply(1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0);

    // Reset right after an accepted read must drop the in-flight word.
    apply(1'b0, 1'b1, 8'h3C, 1'b0, 1, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 8'hA5, 1'b0, 1, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0);

    chk("sb_a_drained", sb_a.size(), 0);
    chk("sb_b_drained", sb_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
